fu_issue_ctrl: RTL and testbench

- Initiator side of the functional-unit EN/finish interface.
- Accepts one decoded instruction per cycle and checks RAW/WAW/structural hazards against a register status table.
- Drives the selected FU's enable with registered operands, then collects each FU's one-cycle finish pulse and result.
- Serialises completions onto a single register-file write-back port.
- Sits between decode/issue and the FU bank (ALU, and later multi-cycle FUs).

---
 rtl/fu_issue_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_fu_issue_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fu_issue_ctrl
//
// Initiator side of the functional-unit EN/finish interface. Accepts one
// decoded instruction per cycle, blocks on RAW/WAW/structural hazards using a
// register status table, pulses the selected FU's enable with registered
// operands, captures each FU's one-cycle finish pulse and result, and retires
// completions one per cycle onto a single register-file write-back port.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid/issue_ready  issue handshake (ready is combinational)
//   issue_fu                 target FU ID, 1..NUM_FU (0 = none)
//   issue_ctrl               operation code forwarded to the FU
//   issue_rd/rs1/rs2         destination / source register indices
//   issue_a/issue_b          operand values
//   fu_en                    one-hot FU enable, bit i -> FU ID i+1
//   fu_ctrl/fu_a/fu_b        registered opcode/operands, broadcast to all FUs
//   fu_finish                4-bit finish field per FU (value i+1 on finish)
//   fu_res                   XLEN-bit result field per FU
//   wb_en/wb_rd/wb_data      register-file write-back port
//   err                      sticky protocol-error flag
// -----------------------------------------------------------------------------
module fu_issue_ctrl #(
    parameter int NUM_FU = 4,
    parameter int XLEN   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [3:0]             issue_fu,
    input  logic [3:0]             issue_ctrl,
    input  logic [4:0]             issue_rd,
    input  logic [4:0]             issue_rs1,
    input  logic [4:0]             issue_rs2,
    input  logic [XLEN-1:0]        issue_a,
    input  logic [XLEN-1:0]        issue_b,
    output logic [NUM_FU-1:0]      fu_en,
    output logic [3:0]             fu_ctrl,
    output logic [XLEN-1:0]        fu_a,
    output logic [XLEN-1:0]        fu_b,
    input  logic [4*NUM_FU-1:0]    fu_finish,
    input  logic [XLEN*NUM_FU-1:0] fu_res,
    output logic                   wb_en,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic                   err
);

    // Per-FU tracking state
    logic [NUM_FU-1:0] busy_q, busy_d;
    logic [NUM_FU-1:0] done_q, done_d;
    logic [4:0]        dest_q [NUM_FU];
    logic [4:0]        dest_d [NUM_FU];
    logic [XLEN-1:0]   res_q  [NUM_FU];
    logic [XLEN-1:0]   res_d  [NUM_FU];

    // Register status table: producing FU ID, 0 when no write is pending
    logic [3:0]        stat_q [32];
    logic [3:0]        stat_d [32];

    // FU-side outputs and error flag
    logic [NUM_FU-1:0] fu_en_q, fu_en_d;
    logic [3:0]        fu_ctrl_q, fu_ctrl_d;
    logic [XLEN-1:0]   fu_a_q, fu_a_d;
    logic [XLEN-1:0]   fu_b_q, fu_b_d;
    logic              err_q, err_d;

    // Combinational helpers
    logic              fu_ok_s;
    logic              fu_busy_s;
    logic              issue_fire_s;
    logic [NUM_FU-1:0] wb_gnt_s;
    logic              wb_hit_s;
    logic [4:0]        wb_dest_s;
    logic [XLEN-1:0]   wb_res_s;

    // Issue acceptance: legal FU ID, FU idle, no pending write to rs1/rs2/rd.
    // A register retiring this cycle still shows as pending (no bypass).
    always_comb begin
        fu_ok_s   = 1'b0;
        fu_busy_s = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ok_s   = fu_ok_s | (issue_fu == 4'(i + 1));
            fu_busy_s = fu_busy_s | (busy_q[i] & (issue_fu == 4'(i + 1)));
        end
        issue_ready  = fu_ok_s && !fu_busy_s
                    && (stat_q[issue_rs1] == 4'd0)
                    && (stat_q[issue_rs2] == 4'd0)
                    && (stat_q[issue_rd]  == 4'd0);
        issue_fire_s = issue_valid & issue_ready;
    end

    // Fixed-priority write-back select: lowest-index done FU retires.
    always_comb begin
        wb_gnt_s  = {NUM_FU{1'b0}};
        wb_hit_s  = 1'b0;
        wb_dest_s = 5'd0;
        wb_res_s  = {XLEN{1'b0}};
        for (int i = 0; i < NUM_FU; i++) begin
            if (done_q[i] && !wb_hit_s) begin
                wb_gnt_s[i] = 1'b1;
                wb_hit_s    = 1'b1;
                wb_dest_s   = dest_q[i];
                wb_res_s    = res_q[i];
            end else begin
                wb_gnt_s[i] = 1'b0;
            end
        end
        // A retirement with rd = 0 frees the FU but writes nothing.
        wb_en   = wb_hit_s && (wb_dest_s != 5'd0);
        wb_rd   = wb_en ? wb_dest_s : 5'd0;
        wb_data = wb_en ? wb_res_s : {XLEN{1'b0}};
    end

    // Next-state: retire, capture finishes, then accept the new issue.
    always_comb begin
        busy_d    = busy_q;
        done_d    = done_q;
        dest_d    = dest_q;
        res_d     = res_q;
        stat_d    = stat_q;
        fu_en_d   = {NUM_FU{1'b0}};
        fu_ctrl_d = fu_ctrl_q;
        fu_a_d    = fu_a_q;
        fu_b_d    = fu_b_q;
        err_d     = err_q;

        // Retirement. The status entry is only released if no younger
        // producer has claimed the register since.
        for (int i = 0; i < NUM_FU; i++) begin
            if (wb_gnt_s[i]) begin
                done_d[i] = 1'b0;
                busy_d[i] = 1'b0;
                if (stat_q[dest_q[i]] == 4'(i + 1)) begin
                    stat_d[dest_q[i]] = 4'd0;
                end else begin
                    stat_d[dest_q[i]] = stat_q[dest_q[i]];
                end
            end else begin
                busy_d[i] = busy_d[i];
            end
        end

        // Finish capture. Unexpected, malformed or duplicate finishes are
        // dropped and raise the sticky error.
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_finish[4*i +: 4] == 4'(i + 1)) begin
                if (busy_q[i] && !done_q[i]) begin
                    done_d[i] = 1'b1;
                    res_d[i]  = fu_res[XLEN*i +: XLEN];
                end else begin
                    err_d = 1'b1;
                end
            end else if (fu_finish[4*i +: 4] != 4'd0) begin
                err_d = 1'b1;
            end else begin
                err_d = err_d;
            end
        end

        // Issue. The retiring register cannot equal issue_rd here because
        // issue requires stat[rd] == 0, so the set below never races a clear.
        if (issue_fire_s) begin
            fu_ctrl_d = issue_ctrl;
            fu_a_d    = issue_a;
            fu_b_d    = issue_b;
            for (int i = 0; i < NUM_FU; i++) begin
                if (issue_fu == 4'(i + 1)) begin
                    busy_d[i]  = 1'b1;
                    dest_d[i]  = issue_rd;
                    fu_en_d[i] = 1'b1;
                end else begin
                    fu_en_d[i] = 1'b0;
                end
            end
            if (issue_rd != 5'd0) begin
                stat_d[issue_rd] = issue_fu;
            end else begin
                stat_d[0] = 4'd0;
            end
        end else begin
            fu_en_d = {NUM_FU{1'b0}};
        end

        // x0 never has a pending writer.
        stat_d[0] = 4'd0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= {NUM_FU{1'b0}};
            done_q    <= {NUM_FU{1'b0}};
            for (int i = 0; i < NUM_FU; i++) begin
                dest_q[i] <= 5'd0;
                res_q[i]  <= {XLEN{1'b0}};
            end
            for (int r = 0; r < 32; r++) begin
                stat_q[r] <= 4'd0;
            end
            fu_en_q   <= {NUM_FU{1'b0}};
            fu_ctrl_q <= 4'd0;
            fu_a_q    <= {XLEN{1'b0}};
            fu_b_q    <= {XLEN{1'b0}};
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            dest_q    <= dest_d;
            res_q     <= res_d;
            stat_q    <= stat_d;
            fu_en_q   <= fu_en_d;
            fu_ctrl_q <= fu_ctrl_d;
            fu_a_q    <= fu_a_d;
            fu_b_q    <= fu_b_d;
            err_q     <= err_d;
        end
    end

    assign fu_en   = fu_en_q;
    assign fu_ctrl = fu_ctrl_q;
    assign fu_a    = fu_a_q;
    assign fu_b    = fu_b_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fu_issue_ctrl
//
// Scoreboard bench for fu_issue_ctrl. A behavioural model (per-FU busy/done
// flags, a pending-writer array per register, and a "lowest done FU retires"
// rule) predicts issue_ready, FU-side outputs and err every cycle, and pushes
// each predicted register write-back into a queue. An independent monitor pops
// that queue whenever the DUT presents (or should present) a write-back.
// A small FU-bank model answers fu_en pulses with finish pulses after a random
// or forced latency, computing its result from the DUT's broadcast operands.
// -----------------------------------------------------------------------------
module tb_fu_issue_ctrl;

    localparam int NUM_FU = 4;
    localparam int XLEN   = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   issue_valid = 1'b0;
    logic                   issue_ready;
    logic [3:0]             issue_fu = 4'd0;
    logic [3:0]             issue_ctrl = 4'd0;
    logic [4:0]             issue_rd = 5'd0;
    logic [4:0]             issue_rs1 = 5'd0;
    logic [4:0]             issue_rs2 = 5'd0;
    logic [XLEN-1:0]        issue_a = '0;
    logic [XLEN-1:0]        issue_b = '0;
    logic [NUM_FU-1:0]      fu_en;
    logic [3:0]             fu_ctrl;
    logic [XLEN-1:0]        fu_a;
    logic [XLEN-1:0]        fu_b;
    logic [4*NUM_FU-1:0]    fu_finish = '0;
    logic [XLEN*NUM_FU-1:0] fu_res = '0;
    logic                   wb_en;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_data;
    logic                   err;

    fu_issue_ctrl #(.NUM_FU(NUM_FU), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_fu(issue_fu), .issue_ctrl(issue_ctrl),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_a(issue_a), .issue_b(issue_b),
        .fu_en(fu_en), .fu_ctrl(fu_ctrl), .fu_a(fu_a), .fu_b(fu_b),
        .fu_finish(fu_finish), .fu_res(fu_res),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit              m_busy [NUM_FU];
    bit              m_done [NUM_FU];
    int              m_dest [NUM_FU];
    logic [XLEN-1:0] m_exp  [NUM_FU];
    int              m_pend [32];
    bit              m_err;
    logic [NUM_FU-1:0] e_en;
    logic [3:0]      e_ctrl;
    logic [XLEN-1:0] e_a, e_b;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;
    wb_t sb_q[$];
    wb_t mon_e;

    // FU bank model
    int              fu_cnt   [NUM_FU];
    logic [XLEN-1:0] fu_r     [NUM_FU];
    int              lat_force[NUM_FU];
    logic [3:0]      drv_fin  [NUM_FU];
    int              inj_fu = -1;
    logic [3:0]      inj_val = 4'd0;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [XLEN-1:0] alu(input logic [3:0] c,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        if (c == 4'd1) return a + b;
        return (a ^ b) + XLEN'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_ready(input int fu, input int rd, input int rs1, input int rs2);
        if (fu < 1 || fu > NUM_FU) return 1'b0;
        if (m_busy[fu-1]) return 1'b0;
        return (m_pend[rs1] == 0) && (m_pend[rs2] == 0) && (m_pend[rd] == 0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_FU; i++) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b0; m_dest[i] = 0; m_exp[i] = '0;
            fu_cnt[i] = -1;
        end
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_err = 1'b0; e_en = '0; e_ctrl = 4'd0; e_a = '0; e_b = '0;
        sb_q.delete();
    endtask

    // One clock cycle: entered and left just after a rising edge.
    task automatic cycle(input bit v, input int fu, input int ctrl, input int rd,
                         input int rs1, input int rs2,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int r;
        bit rdy;
        issue_valid = v;
        issue_fu    = 4'(fu);
        issue_ctrl  = 4'(ctrl);
        issue_rd    = 5'(rd);
        issue_rs1   = 5'(rs1);
        issue_rs2   = 5'(rs2);
        issue_a     = a;
        issue_b     = b;
        // FU bank: start on enable, finish when the countdown reaches zero
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_en[i]) begin
                fu_cnt[i] = (lat_force[i] >= 0) ? lat_force[i] : int'($urandom_range(0, 3));
                fu_r[i]   = alu(fu_ctrl, fu_a, fu_b);
            end
        end
        fu_finish = '0;
        fu_res    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            drv_fin[i] = 4'd0;
            if (fu_cnt[i] == 0) begin
                drv_fin[i] = 4'(i + 1);
                fu_res[XLEN*i +: XLEN] = fu_r[i];
                fu_cnt[i] = -1;
            end else if (fu_cnt[i] > 0) begin
                fu_cnt[i]--;
            end
        end
        if (inj_fu >= 0) begin
            drv_fin[inj_fu] = inj_val;
            inj_fu = -1;
        end
        for (int i = 0; i < NUM_FU; i++) fu_finish[4*i +: 4] = drv_fin[i];
        // Predicted retirement this cycle
        r = -1;
        for (int i = 0; i < NUM_FU; i++) if (m_done[i] && r < 0) r = i;
        if (r >= 0 && m_dest[r] != 0) sb_q.push_back({5'(m_dest[r]), m_exp[r]});
        rdy = m_ready(fu, rd, rs1, rs2);

        @(negedge clk);
        chk("issue_ready", 64'(issue_ready), 64'(rdy));
        chk("fu_en",       64'(fu_en),       64'(e_en));
        chk("fu_ctrl",     64'(fu_ctrl),     64'(e_ctrl));
        chk("fu_a",        64'(fu_a),        64'(e_a));
        chk("fu_b",        64'(fu_b),        64'(e_b));
        chk("err",         64'(err),         64'(m_err));

        @(posedge clk);
        if (r >= 0) begin
            m_busy[r] = 1'b0;
            m_done[r] = 1'b0;
            if (m_pend[m_dest[r]] == r + 1) m_pend[m_dest[r]] = 0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (drv_fin[i] == 4'(i + 1)) begin
                if (m_busy[i] && !m_done[i]) m_done[i] = 1'b1;
                else m_err = 1'b1;
            end else if (drv_fin[i] != 4'd0) begin
                m_err = 1'b1;
            end
        end
        e_en = '0;
        if (v && rdy) begin
            m_busy[fu-1] = 1'b1;
            m_dest[fu-1] = rd;
            m_exp[fu-1]  = alu(4'(ctrl), a, b);
            if (rd != 0) m_pend[rd] = fu;
            e_en[fu-1] = 1'b1;
            e_ctrl = 4'(ctrl);
            e_a = a;
            e_b = b;
        end
        #1;
    endtask

    task automatic iss(input int fu, input int ctrl, input int rd, input int rs1,
                       input int rs2, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        cycle(1'b1, fu, ctrl, rd, rs1, rs2, a, b);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    // Reset asserted mid-cycle; checks the cleared state, then releases.
    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        fu_finish = '0;
        fu_res = '0;
        @(negedge clk);
        chk("rst_fu_en",   64'(fu_en),   64'd0);
        chk("rst_fu_ctrl", 64'(fu_ctrl), 64'd0);
        chk("rst_fu_a",    64'(fu_a),    64'd0);
        chk("rst_fu_b",    64'(fu_b),    64'd0);
        chk("rst_wb_rd",   64'(wb_rd),   64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_err",     64'(err),     64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Write-back monitor: every presented write-back must match the head of
    // the scoreboard, and a predicted one must not be missing.
    always @(negedge clk) begin
        if (sb_q.size() == 0) begin
            chk("wb_en_idle", 64'(wb_en), 64'd0);
        end else begin
            mon_e = sb_q.pop_front();
            chk("wb_en",   64'(wb_en),   64'd1);
            chk("wb_rd",   64'(wb_rd),   64'(mon_e.rd));
            chk("wb_data", 64'(wb_data), 64'(mon_e.data));
        end
    end

    initial begin
        for (int i = 0; i < NUM_FU; i++) lat_force[i] = -1;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Single op, then keep offering FU1 until it is free again
        lat_force[0] = 1;
        iss(1, 1, 5, 0, 0, 32'd3, 32'd4);
        for (int k = 0; k < 6; k++) iss(1, 1, 6, 0, 0, 32'd10, 32'd20);
        idle(5);

        // RAW stall on x5
        lat_force[0] = 2;
        iss(1, 1, 5, 0, 0, 32'd100, 32'd1);
        for (int k = 0; k < 7; k++) iss(2, 3, 7, 5, 0, 32'h55, 32'h0f);
        idle(6);

        // Simultaneous finish of FU1 and FU2
        lat_force[0] = 1;
        lat_force[1] = 0;
        iss(1, 1, 3, 0, 0, 32'h10, 32'h1);
        iss(2, 1, 4, 0, 0, 32'h20, 32'h2);
        idle(5);

        // rd = 0 on FU3, back-to-back with an unrelated issue
        lat_force[2] = 1;
        iss(3, 2, 0, 1, 2, 32'h7, 32'h9);
        iss(1, 1, 8, 0, 0, 32'h1, 32'h1);
        idle(5);

        // Structural and WAW blocking
        lat_force[0] = 3;
        iss(1, 1, 9, 0, 0, 32'h3, 32'h3);
        iss(1, 1, 10, 0, 0, 32'h4, 32'h4);
        iss(2, 1, 9, 0, 0, 32'h5, 32'h5);
        idle(8);

        // Finish from an idle FU, then a malformed finish value
        inj_fu = 1; inj_val = 4'd2;
        idle(3);
        inj_fu = 0; inj_val = 4'd3;
        idle(2);

        // Reset with FU1 busy; any legal request is accepted afterwards
        iss(1, 1, 12, 0, 0, 32'h8, 32'h8);
        idle(1);
        do_reset();
        iss(1, 1, 12, 12, 12, 32'h9, 32'h9);
        idle(6);

        // Randomised traffic with a small register window to force hazards
        for (int i = 0; i < NUM_FU; i++) lat_force[i] = -1;
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, NUM_FU + 1)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      XLEN'($urandom), XLEN'($urandom));
            end
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
